// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//    Time-multiplexed N-digit seven-segment display driver. A packed hex word
//    and per-digit enables are captured into shadow registers on a load strobe.
//    The driver then scans one digit per refresh slot of DIV clocks. Each slot
//    starts with a single dead cycle in which every anode is released, so the
//    previous digit cannot ghost into the next one. Segment patterns come from
//    a fixed hex decode table. All outputs are registered.
//
// Parameters
//    DIGITS  number of digits scanned (1..8); digit 0 is rightmost, nibble [3:0]
//    DIV     clocks per digit slot (>= 2)
//
// Ports
//    clk        in   1          system clock, rising edge
//    reset      in   1          synchronous, active-high
//    load       in   1          capture strobe for digit_val / digit_en
//    digit_val  in   4*DIGITS   packed hex nibbles, nibble k = digit k
//    digit_en   in   DIGITS     1 = digit k displayed, 0 = digit k blanked
//    dp_val     in   DIGITS     decimal-point values (SEG_DP_EN builds only)
//    dp         out  1          decimal point, active-high (SEG_DP_EN builds only)
//    seg        out  7          segments g..a (seg[0] = a), active-high
//    an         out  DIGITS     anodes, active-low; one low or all high
//    frame      out  1          one-cycle pulse when the last digit slot completes
//
// Configuration
//    SEG_DP_EN  when defined, adds the dp_val input and the dp output.
//               dp_val is captured on load like digit_val. dp follows the same
//               drive condition as seg.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int DIGITS = 4,
   parameter int DIV    = 16384
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   digit_val,
   input  logic [DIGITS-1:0]     digit_en,
`ifdef SEG_DP_EN
   input  logic [DIGITS-1:0]     dp_val,
   output logic                  dp,
`endif
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] val_q, val_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_q, frame_d;
`ifdef SEG_DP_EN
   logic [DIGITS-1:0]   dpv_q, dpv_d;
   logic                dp_q, dp_d;
`endif

   logic                last_cnt;
   logic                last_idx;
   logic                drive;
   logic [3:0]          nib;

   // Hex nibble to segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      val_d   = val_q;
      en_d    = en_q;
      if (load) begin
         val_d = digit_val;
         en_d  = digit_en;
      end

      last_cnt = (cnt_q == CW'(DIV - 1));
      last_idx = (idx_q == IW'(DIGITS - 1));

      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (last_cnt) begin
         idx_d = last_idx ? '0 : idx_q + 1'b1;
      end
      frame_d = last_cnt && last_idx;

      // cnt == 0 is the dead cycle of every slot: no anode is driven.
      nib   = val_q[idx_q*4 +: 4];
      drive = (cnt_q != '0) && en_q[idx_q];
      an_d  = '1;
      seg_d = '0;
      if (drive) begin
         an_d[idx_q] = 1'b0;
         seg_d       = hex7(nib);
      end

`ifdef SEG_DP_EN
      dpv_d = load ? dp_val : dpv_q;
      dp_d  = drive && dpv_q[idx_q];
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         val_q   <= '0;
         en_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= '0;
         an_q    <= '1;
         frame_q <= 1'b0;
`ifdef SEG_DP_EN
         dpv_q   <= '0;
         dp_q    <= 1'b0;
`endif
      end else begin
         val_q   <= val_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= frame_d;
`ifdef SEG_DP_EN
         dpv_q   <= dpv_d;
         dp_q    <= dp_d;
`endif
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = frame_q;
`ifdef SEG_DP_EN
   assign dp    = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//    Directed bench for seg_scan_driver with DIGITS=4, DIV=4. A reference model
//    derives slot position from the number of cycles elapsed since reset. It
//    tracks the shadow registers from the loads it drives. Each step pushes the
//    expected registered outputs to a scoreboard queue. It then pops that
//    entry and compares it against the pins one time unit after the clock edge.
//    Inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic       frame;
      logic       dp;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] digit_val;
   logic [3:0]  digit_en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame;
`ifdef SEG_DP_EN
   logic [3:0]  dp_val;
   logic        dp;
   logic [3:0]  dp_drv;
   logic [3:0]  sh_dp;
`endif

   // Reference model state.
   int          t;
   logic [15:0] sh_val;
   logic [3:0]  sh_en;
   exp_t        sb[$];

   int passed = 0;
   int total  = 0;

   logic [6:0] ref_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .digit_val (digit_val),
      .digit_en  (digit_en),
`ifdef SEG_DP_EN
      .dp_val    (dp_val),
      .dp        (dp),
`endif
      .seg       (seg),
      .an        (an),
      .frame     (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   // One clock: drive inputs, push the expectation, advance the model, compare.
   task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] e);
      exp_t x;
      int   cnt;
      int   idx;
      logic drv;
      @(negedge clk);
      reset     = rst;
      load      = ld;
      digit_val = v;
      digit_en  = e;
`ifdef SEG_DP_EN
      dp_val    = dp_drv;
`endif
      cnt = t % DIV;
      idx = (t / DIV) % DIGITS;
      drv = (cnt != 0) && sh_en[idx];
      x.an    = drv ? ~(4'b0001 << idx) : 4'hF;
      x.seg   = drv ? ref_tab[sh_val[idx*4 +: 4]] : 7'h00;
      x.frame = (cnt == DIV - 1) && (idx == DIGITS - 1);
      x.dp    = 1'b0;
`ifdef SEG_DP_EN
      x.dp    = drv && sh_dp[idx];
`endif
      if (rst) x = '{seg: 7'h00, an: 4'hF, frame: 1'b0, dp: 1'b0};
      sb.push_back(x);

      if (rst) begin
         t      = 0;
         sh_val = '0;
         sh_en  = '0;
`ifdef SEG_DP_EN
         sh_dp  = '0;
`endif
      end else begin
         t++;
         if (ld) begin
            sh_val = v;
            sh_en  = e;
`ifdef SEG_DP_EN
            sh_dp  = dp_drv;
`endif
         end
      end

      @(posedge clk);
      #1;
      x = sb.pop_front();
      check("an",    {4'h0, an},    {4'h0, x.an});
      check("seg",   {1'b0, seg},   {1'b0, x.seg});
      check("frame", {7'h0, frame}, {7'h0, x.frame});
      check("an_onehot", 8'($countones(~an) <= 1), 8'd1);
`ifdef SEG_DP_EN
      check("dp",    {7'h0, dp},    {7'h0, x.dp});
`endif
   endtask

   // Idle cycles with noise on the data inputs; without load it must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   initial begin
      t         = 0;
      sh_val    = '0;
      sh_en     = '0;
      reset     = 1'b1;
      load      = 1'b0;
      digit_val = '0;
      digit_en  = '0;
`ifdef SEG_DP_EN
      dp_drv    = '0;
      sh_dp     = '0;
      dp_val    = '0;
`endif

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);

      // Load 1234 with all digits enabled; two full frames with input noise.
      step(1'b0, 1'b1, 16'h1234, 4'hF);
      idle(33);

      // Load ABCD with digits 1 and 3 blanked.
      step(1'b0, 1'b1, 16'hABCD, 4'b0101);
      idle(17);

      // Load 0000 on a slot-wrap edge, then FFFF one cycle into the next slot.
      for (int i = 0; i < DIV * DIGITS && (t % DIV) != DIV - 1; i++) idle(1);
      step(1'b0, 1'b1, 16'h0000, 4'hF);
      idle(1);
      step(1'b0, 1'b1, 16'hFFFF, 4'hF);
      idle(6);

      // Reset mid-operation at idx 2, cnt 2; shadow must come back cleared.
      for (int i = 0; i < 2 * DIV * DIGITS && !((t % DIV) == 2 && ((t / DIV) % DIGITS) == 2); i++)
         idle(1);
      step(1'b1, 1'b0, 16'h5555, 4'hF);
      idle(18);

      // Sweep every nibble through the decoder.
`ifdef SEG_DP_EN
      dp_drv = 4'b0010;
`endif
      step(1'b0, 1'b1, 16'h3210, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'h7654, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'hBA98, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'hFEDC, 4'hF);
      idle(17);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
